// File: rtl/afifo_pkg.sv
// Shared definitions for the asynchronous FIFO neighbours: read-side state
// encoding, width helpers and default entry/lane sizes.
package afifo_pkg;

  localparam int AFIFO_DSIZE = 8;
  localparam int AFIFO_LANES = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } rd_state_e;

  // Width of the lane index (0..lanes-1)
  function automatic int lidx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Width of a lane count (0..lanes)
  function automatic int cnt_width(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/afifo_rd_packer_if.sv
// Packed-word valid/ready stream leaving the FIFO read-side packer.
// master = producer of words, slave = downstream consumer.
interface afifo_rd_packer_if
  import afifo_pkg::*;
#(
  parameter int DSIZE = AFIFO_DSIZE,
  parameter int LANES = AFIFO_LANES
);

  localparam int CW = cnt_width(LANES);

  logic                   out_valid;
  logic                   out_ready;
  logic [DSIZE*LANES-1:0] out_data;
  logic [CW-1:0]          out_cnt;

  modport master (
    output out_valid,
    output out_data,
    output out_cnt,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_cnt,
    output out_ready
  );

endinterface

// File: rtl/afifo_idle_timer.sv
// Idle timer for the read-side packer: counts enabled cycles and raises
// expire on the TMO-th consecutive one. Used only when AFIFO_RD_TIMEOUT_EN
// is defined.
module afifo_idle_timer #(
  parameter int TMO = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(TMO + 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Expire combinationally on the TMO-th idle cycle so the owner can act on
  // the same edge
  assign expire = en & ~clr & (cnt_q == TW'(TMO - 1));

  // Next count: restart on clear or expiry, otherwise advance while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr || expire) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/afifo_rd_packer.sv
// Read-domain consumer of the asynchronous FIFO. Pops DSIZE-bit entries
// while the FIFO is non-empty and packs LANES of them (lane 0 = oldest)
// into one word presented on a valid/ready stream.
// Optional feature macro: AFIFO_RD_TIMEOUT_EN -- flush a partial word after
// TMO idle cycles; without it partial words wait indefinitely.
module afifo_rd_packer
  import afifo_pkg::*;
#(
  parameter int DSIZE = AFIFO_DSIZE,
  parameter int LANES = AFIFO_LANES,
  parameter int TMO   = 16
) (
  input  logic             rclk,
  input  logic             rst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  afifo_rd_packer_if.master out_if
);

  localparam int LW = lidx_width(LANES);
  localparam int CW = cnt_width(LANES);
  localparam int WW = DSIZE * LANES;

  if (TMO < 1) begin : g_tmo_check
    $error("afifo_rd_packer: TMO must be at least 1");
  end

  rd_state_e     state_q, state_d;
  logic [LW-1:0] lidx_q, lidx_d;
  logic [WW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          pop;
  logic          tmo_expire;

  // Pop only while filling and the FIFO has data; never during reset
  assign pop  = (state_q == FILL) & ~rempty & ~rst;
  assign rinc = pop;

`ifdef AFIFO_RD_TIMEOUT_EN
  logic tmo_en;
  logic tmo_clr;

  // Idle = filling with a partial word in flight and nothing popped
  assign tmo_en  = (state_q == FILL) & (lidx_q != '0) & ~pop;
  assign tmo_clr = (state_q != FILL) | pop;

  afifo_idle_timer #(
    .TMO (TMO)
  ) u_idle_timer (
    .clk    (rclk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  // Next-state logic: fill lanes on pops, hold the word until accepted
  always_comb begin
    state_d = state_q;
    lidx_d  = lidx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    case (state_q)
      FILL: begin
        if (pop) begin
          data_d[int'(lidx_q)*DSIZE +: DSIZE] = rdata;
          if (lidx_q == LW'(LANES - 1)) begin
            lidx_d  = '0;
            cnt_d   = CW'(LANES);
            state_d = HOLD;
            valid_d = 1'b1;
          end else begin
            lidx_d = lidx_q + 1'b1;
          end
        end else if (tmo_expire) begin
          // Partial flush: unwritten upper lanes are already zero
          lidx_d  = '0;
          cnt_d   = {1'b0, lidx_q};
          state_d = HOLD;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_if.out_ready) begin
          valid_d = 1'b0;
          data_d  = '0;
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and output registers; reset discards any partially packed word
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      lidx_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lidx_q  <= lidx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_cnt   = cnt_q;

endmodule

// File: tb/tb_afifo_rd_packer.sv
// Directed bench for afifo_rd_packer (DSIZE=8, LANES=4, TMO=16) with a
// behavioural FIFO queue on the read side.
module tb_afifo_rd_packer;

  logic       rclk = 1'b0;
  logic       rst;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;

  afifo_rd_packer_if #(.DSIZE(8), .LANES(4)) oif ();

  afifo_rd_packer #(
    .DSIZE (8),
    .LANES (4),
    .TMO   (16)
  ) dut (
    .rclk   (rclk),
    .rst    (rst),
    .rempty (rempty),
    .rdata  (rdata),
    .rinc   (rinc),
    .out_if (oif)
  );

  always #5 rclk = ~rclk;

  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  logic [7:0]  fq[$];
  logic        stall = 1'b0;
  logic [31:0] got_w[$];
  logic [2:0]  got_c[$];

  function automatic void push_b(input logic [7:0] b);
    fq.push_back(b);
  endfunction

  task automatic settle();
    rempty = (fq.size() == 0) || stall;
    rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
    #1;
  endtask

  // One clock: check pop legality, capture accepted words, advance FIFO
  task automatic cyc();
    logic pop;
    vec_cnt++;
    if (rinc && (rempty || oif.out_valid)) begin
      miss_cnt++;
      $display("FAIL rinc_legal: rinc=%b rempty=%b out_valid=%b, required rinc=0", rinc, rempty, oif.out_valid);
    end
    pop = rinc;
    if (oif.out_valid && oif.out_ready) begin
      got_w.push_back(oif.out_data);
      got_c.push_back(oif.out_cnt);
      $display("word %08h cnt %0d accepted at %0t", oif.out_data, oif.out_cnt, $time);
    end
    @(posedge rclk);
    #1;
    if (pop) void'(fq.pop_front());
    settle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    oif.out_ready = 1'b1;
    push_b(8'h11);
    settle();
    vec_cnt++;
    if (rinc !== 1'b0) begin miss_cnt++; $display("FAIL reset_rinc: got %b want 0", rinc); end
    vec_cnt++;
    if (oif.out_valid !== 1'b0) begin miss_cnt++; $display("FAIL reset_valid: got %b want 0", oif.out_valid); end
    vec_cnt++;
    if (oif.out_data !== 32'h0) begin miss_cnt++; $display("FAIL reset_data: got %h want 0", oif.out_data); end
    vec_cnt++;
    if (oif.out_cnt !== 3'd0) begin miss_cnt++; $display("FAIL reset_cnt: got %0d want 0", oif.out_cnt); end
    cyc();
    vec_cnt++;
    if (fq.size() != 1) begin miss_cnt++; $display("FAIL reset_nopop: fifo size %0d want 1", fq.size()); end
    fq.delete();
    settle();
    rst = 1'b0;
    settle();
  endtask

  task automatic test_basic();
    push_b(8'h11); push_b(8'h22); push_b(8'h33); push_b(8'h44);
    settle();
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (rinc !== 1'b1) begin miss_cnt++; $display("FAIL basic_rinc%0d: got %b want 1", i, rinc); end
      cyc();
    end
    vec_cnt++;
    if (oif.out_valid !== 1'b1) begin miss_cnt++; $display("FAIL basic_valid: got %b want 1", oif.out_valid); end
    vec_cnt++;
    if (oif.out_data !== 32'h44332211) begin miss_cnt++; $display("FAIL basic_data: got %h want 44332211", oif.out_data); end
    vec_cnt++;
    if (oif.out_cnt !== 3'd4) begin miss_cnt++; $display("FAIL basic_cnt: got %0d want 4", oif.out_cnt); end
    cyc();
    vec_cnt++;
    if (oif.out_valid !== 1'b0) begin miss_cnt++; $display("FAIL basic_valid_clr: got %b want 0", oif.out_valid); end
    vec_cnt++;
    if (oif.out_data !== 32'h0) begin miss_cnt++; $display("FAIL basic_data_clr: got %h want 0", oif.out_data); end
  endtask

  task automatic test_backpressure();
    oif.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_b(8'(i));
    settle();
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (rinc !== 1'b1) begin miss_cnt++; $display("FAIL bp_rinc%0d: got %b want 1", i, rinc); end
      cyc();
    end
    for (int i = 0; i < 5; i++) begin
      vec_cnt++;
      if (oif.out_valid !== 1'b1) begin miss_cnt++; $display("FAIL bp_valid%0d: got %b want 1", i, oif.out_valid); end
      vec_cnt++;
      if (oif.out_data !== 32'h04030201) begin miss_cnt++; $display("FAIL bp_data%0d: got %h want 04030201", i, oif.out_data); end
      vec_cnt++;
      if (oif.out_cnt !== 3'd4) begin miss_cnt++; $display("FAIL bp_cnt%0d: got %0d want 4", i, oif.out_cnt); end
      vec_cnt++;
      if (rinc !== 1'b0) begin miss_cnt++; $display("FAIL bp_hold_rinc%0d: got %b want 0", i, rinc); end
      cyc();
    end
    oif.out_ready = 1'b1;
    settle();
    cyc();
    vec_cnt++;
    if (rinc !== 1'b1) begin miss_cnt++; $display("FAIL bp_resume: rinc got %b want 1", rinc); end
    for (int i = 0; i < 4; i++) cyc();
    vec_cnt++;
    if (oif.out_data !== 32'h08070605) begin miss_cnt++; $display("FAIL bp_data2: got %h want 08070605", oif.out_data); end
    vec_cnt++;
    if (oif.out_valid !== 1'b1) begin miss_cnt++; $display("FAIL bp_valid2: got %b want 1", oif.out_valid); end
    cyc();
  endtask

  task automatic test_empty_stall();
    push_b(8'hA1); push_b(8'hA2);
    settle();
    cyc(); cyc();
    for (int i = 0; i < 10; i++) begin
      vec_cnt++;
      if (rinc !== 1'b0 || oif.out_valid !== 1'b0) begin
        miss_cnt++;
        $display("FAIL stall_idle%0d: rinc=%b out_valid=%b want 0/0", i, rinc, oif.out_valid);
      end
      cyc();
    end
    push_b(8'hA3); push_b(8'hA4);
    settle();
    cyc(); cyc();
    vec_cnt++;
    if (oif.out_data !== 32'hA4A3A2A1) begin miss_cnt++; $display("FAIL stall_data: got %h want a4a3a2a1", oif.out_data); end
    vec_cnt++;
    if (oif.out_valid !== 1'b1) begin miss_cnt++; $display("FAIL stall_valid: got %b want 1", oif.out_valid); end
    cyc();
  endtask

  task automatic test_timeout();
    push_b(8'hAA); push_b(8'hBB);
    settle();
    cyc(); cyc();
`ifdef AFIFO_RD_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      vec_cnt++;
      if (oif.out_valid !== 1'b0) begin miss_cnt++; $display("FAIL tmo_early%0d: out_valid got %b want 0", i, oif.out_valid); end
      cyc();
    end
    vec_cnt++;
    if (oif.out_valid !== 1'b1) begin miss_cnt++; $display("FAIL tmo_valid: got %b want 1", oif.out_valid); end
    vec_cnt++;
    if (oif.out_data !== 32'h0000BBAA) begin miss_cnt++; $display("FAIL tmo_data: got %h want 0000bbaa", oif.out_data); end
    vec_cnt++;
    if (oif.out_cnt !== 3'd2) begin miss_cnt++; $display("FAIL tmo_cnt: got %0d want 2", oif.out_cnt); end
    cyc();
`else
    for (int i = 0; i < 40; i++) begin
      vec_cnt++;
      if (oif.out_valid !== 1'b0) begin miss_cnt++; $display("FAIL notmo_valid%0d: got %b want 0", i, oif.out_valid); end
      cyc();
    end
    push_b(8'hCC); push_b(8'hDD);
    settle();
    cyc(); cyc();
    vec_cnt++;
    if (oif.out_data !== 32'hDDCCBBAA) begin miss_cnt++; $display("FAIL notmo_data: got %h want ddccbbaa", oif.out_data); end
    vec_cnt++;
    if (oif.out_cnt !== 3'd4) begin miss_cnt++; $display("FAIL notmo_cnt: got %0d want 4", oif.out_cnt); end
    cyc();
`endif
  endtask

  task automatic test_reset_mid();
    push_b(8'h10); push_b(8'h20); push_b(8'h30);
    settle();
    cyc(); cyc(); cyc();
    vec_cnt++;
    if (oif.out_data !== 32'h00302010) begin miss_cnt++; $display("FAIL rmid_partial: got %h want 00302010", oif.out_data); end
    rst = 1'b1;
    push_b(8'h55);
    settle();
    vec_cnt++;
    if (oif.out_data !== 32'h0) begin miss_cnt++; $display("FAIL rmid_data: got %h want 0", oif.out_data); end
    vec_cnt++;
    if (oif.out_cnt !== 3'd0) begin miss_cnt++; $display("FAIL rmid_cnt: got %0d want 0", oif.out_cnt); end
    vec_cnt++;
    if (oif.out_valid !== 1'b0 || rinc !== 1'b0) begin
      miss_cnt++;
      $display("FAIL rmid_ctl: out_valid=%b rinc=%b want 0/0", oif.out_valid, rinc);
    end
    cyc();
    rst = 1'b0;
    push_b(8'h56); push_b(8'h57); push_b(8'h58);
    settle();
    for (int i = 0; i < 4; i++) cyc();
    vec_cnt++;
    if (oif.out_data !== 32'h58575655) begin miss_cnt++; $display("FAIL rmid_word: got %h want 58575655", oif.out_data); end
    vec_cnt++;
    if (oif.out_valid !== 1'b1) begin miss_cnt++; $display("FAIL rmid_valid: got %b want 1", oif.out_valid); end
    cyc();
  endtask

  task automatic test_long_stream();
    logic [7:0]  exp_b[64];
    logic [31:0] exp_w;
    got_w.delete();
    got_c.delete();
    for (int i = 0; i < 64; i++) begin
      exp_b[i] = 8'($urandom_range(0, 255));
      push_b(exp_b[i]);
    end
    for (int n = 0; n < 2000 && got_w.size() < 16; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      oif.out_ready = ($urandom_range(0, 1) == 1);
      settle();
      cyc();
    end
    stall = 1'b0;
    oif.out_ready = 1'b1;
    settle();
    vec_cnt++;
    if (got_w.size() != 16) begin miss_cnt++; $display("FAIL long_count: got %0d words want 16", got_w.size()); end
    for (int w = 0; w < got_w.size() && w < 16; w++) begin
      exp_w = {exp_b[4*w+3], exp_b[4*w+2], exp_b[4*w+1], exp_b[4*w]};
      vec_cnt++;
      if (got_w[w] !== exp_w || got_c[w] !== 3'd4) begin
        miss_cnt++;
        $display("FAIL long_word%0d: got %h cnt %0d want %h cnt 4", w, got_w[w], got_c[w], exp_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_timeout();
    test_reset_mid();
    test_long_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
